seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Time-multiplexed driver for the board's 4-digit 7-segment display. It produces the 14-bit KW4_56NCWB_P_Y pin vector that dut_top exports to the board model. The block accepts a 16-bit hex value, plus decimal points, per-digit blanks and colon, through a valid/ready handshake. The value is held in a shadow register and committed only at a frame boundary, so a scan never shows a mix of old and new digits.

Parameters:
C_SCAN_CYCLES, 2500, cycles each digit common is driven (≥2); 1 kHz frame rate at 10 MHz.
C_BLANK_CYCLES, 16, anti-ghosting gap before each digit with all outputs off (≥1).
C_SEG_ACTIVE_LOW, 0, 1 inverts the segment, dp and colon pins.
C_COM_ACTIVE_LOW, 0, 1 inverts the digit-common pins.

Ports:
CLK  in  1  the single clock (CLK_10MHz domain).
RST  in  1  asynchronous, active-high reset.
IN_VALID  in  1  update request.
IN_READY  out  1  shadow register free.
IN_HEX  in  16  digit3..digit0 nibbles, digit0 = IN_HEX[3:0].
IN_DP  in  4  per-digit decimal point.
IN_BLANK  in  4  per-digit blank (segments and dp off, common still scanned).
IN_COLON  in  1  colon LED.
FRAME_TICK  out  1  1-cycle pulse on the commit cycle.
PINS  out  14  [7:0] = {dp,g,f,e,d,c,b,a}; [11:8] = one-hot digit common, bit 8 = digit0; [12] = colon; [13] = tied inactive.

Behaviour:
- All outputs registered; PINS updates one cycle after the internal state/counter change.
- Reset state:
  - PINS all inactive (respecting the polarity parameters); IN_READY=1; FRAME_TICK=0.
  - Active and shadow registers = all digits blanked, colon off.
  - FSM = BLANK, digit=0, cnt=0.
- FSM states and transitions:
  - BLANK: lasts C_BLANK_CYCLES cycles; segments, commons and colon inactive.
  - SCAN: lasts C_SCAN_CYCLES cycles; the selected common is active; segments = font(active nibble) | dp, forced off if that digit is blanked.
  - SCAN terminal cycle → BLANK with digit+1; digit wraps 3→0.
  - One digit slot = C_BLANK_CYCLES + C_SCAN_CYCLES cycles; one frame = 4 slots.
- Colon: active during every SCAN phase while the active colon bit is set; off during BLANK.
- Font: active-high segment code, bit0 = a.
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Handshake:
  - Transfer occurs on IN_VALID & IN_READY; the shadow captures all inputs and pending=1.
  - IN_READY = !pending, registered, so it falls the cycle after the transfer.
- Commit:
  - Occurs on the first BLANK cycle of digit0 (frame boundary), only if pending=1.
  - Commit copies shadow→active, clears pending, and pulses FRAME_TICK that cycle.
  - IN_READY returns high the next cycle.
- Simultaneous transfer and frame-boundary cycle: the transfer lands in the shadow and is committed at the following frame boundary, not the current one.
- No commit when pending=0: the active register holds its value and FRAME_TICK stays 0.
- IN_VALID while IN_READY=0: ignored. The data is not captured and the source must hold it.
- Reset mid-frame: immediate return to the reset state; any pending update is discarded.
- Width rules:
  - cnt is wide enough for max(C_SCAN_CYCLES, C_BLANK_CYCLES)-1 (clog2).
  - digit is a 2-bit wrapping counter.

Decomposition:
- Shared package seg7_pkg contains:
  - state enum {BLANK, SCAN};
  - pin-index localparams (SEG_LSB=0, COM_LSB=8, COLON=12);
  - 16-entry font constant array.
- One sub-module: seg7_hex_decode, combinational nibble+dp+blank → 8-bit segment code. It is instantiated once, on the muxed current digit.

Test Plan:
(All scenarios use C_SCAN_CYCLES=4, C_BLANK_CYCLES=2 unless stated; slot = 6 cycles, frame = 24 cycles.)
1. Reset: hold RST 3 cycles, release → PINS=14'h0000, IN_READY=1 throughout reset and after; no commons asserted until the first SCAN.
2. Write IN_HEX=16'h12AF, IN_DP=4'b0100, IN_COLON=1 → FRAME_TICK at the next digit0 BLANK start. Then per frame:
   - PINS[11:8]=0001 with [7:0]=71;
   - then 0010 with 77;
   - then 0100 with DB (5B|dp);
   - then 1000 with 06;
   - [12]=1 in SCAN only; each common high exactly 4 cycles, preceded by 2 dark cycles.
3. Handshake: second IN_VALID held while IN_READY=0 → not captured. Commit → IN_READY=1 next cycle, the held value transfers, and it is displayed one frame later.
4. Transfer on the frame-boundary cycle → no FRAME_TICK that frame; commit exactly 24 cycles later.
5. IN_BLANK=4'b1111 with C_SEG_ACTIVE_LOW=1, C_COM_ACTIVE_LOW=1 → segments constantly 8'hFF, commons still scan active-low (1110, 1101, ...).
6. Assert RST mid-SCAN of digit2 with an update pending → PINS inactive within the same cycle (async), IN_READY=1, and the pending value is never displayed.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
package seg7_pkg;
  typedef enum logic {BLANK, SCAN} state_t;

  localparam int SEG_LSB = 0;
  localparam int COM_LSB = 8;
  localparam int COLON   = 12;

  // Active-high segment codes, bit0 = a
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        colon;
  } disp_t;

  localparam disp_t DISP_RST = '{hex: 16'h0000, dp: 4'h0, blank: 4'hF, colon: 1'b0};
endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble + decimal point + blank to active-high {dp,g..a} segment code.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);
  assign seg = blank ? 8'h00 : {dp, FONT[nib]};
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver; shadowed updates commit only at frame start.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int C_SCAN_CYCLES    = 2500,
  parameter int C_BLANK_CYCLES   = 16,
  parameter int C_SEG_ACTIVE_LOW = 0,
  parameter int C_COM_ACTIVE_LOW = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] IN_HEX,
  input  logic [3:0]  IN_DP,
  input  logic [3:0]  IN_BLANK,
  input  logic        IN_COLON,
  output logic        FRAME_TICK,
  output logic [13:0] PINS
);
  localparam int CMAX = (C_SCAN_CYCLES > C_BLANK_CYCLES) ? C_SCAN_CYCLES : C_BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] SCAN_END  = CW'(C_SCAN_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(C_BLANK_CYCLES - 1);
  localparam logic SEG_INV = (C_SEG_ACTIVE_LOW != 0);
  localparam logic COM_INV = (C_COM_ACTIVE_LOW != 0);
  // Spare pin 13 follows segment polarity so it always sits at the inactive level
  localparam logic [13:0] POL_MASK = {{2{SEG_INV}}, {4{COM_INV}}, {8{SEG_INV}}};

  state_t        state;
  logic [1:0]    digit;
  logic [CW-1:0] cnt;
  disp_t         shadow, active;
  logic          pending;

  logic          xfer, commit, pending_nxt;
  logic [7:0]    seg_code;
  logic [13:0]   pins_nxt;

  assign xfer        = IN_VALID & IN_READY;
  assign commit      = pending & (state == BLANK) & (digit == 2'd0) & (cnt == '0);
  assign pending_nxt = commit ? 1'b0 : (pending | xfer);

  seg7_hex_decode u_dec (
    .nib   (active.hex[{digit, 2'b00} +: 4]),
    .dp    (active.dp[digit]),
    .blank (active.blank[digit]),
    .seg   (seg_code)
  );

  always_comb begin
    pins_nxt = '0;
    if (state == SCAN) begin
      pins_nxt[SEG_LSB +: 8] = seg_code;
      pins_nxt[COM_LSB +: 4] = 4'b0001 << digit;
      pins_nxt[COLON]        = active.colon;
    end
    pins_nxt = pins_nxt ^ POL_MASK;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= BLANK;
      digit      <= '0;
      cnt        <= '0;
      shadow     <= DISP_RST;
      active     <= DISP_RST;
      pending    <= 1'b0;
      IN_READY   <= 1'b1;
      FRAME_TICK <= 1'b0;
      PINS       <= POL_MASK;
    end else begin
      PINS       <= pins_nxt;
      FRAME_TICK <= commit;
      pending    <= pending_nxt;
      // Ready tracks next pending so it drops right after a transfer
      IN_READY   <= ~pending_nxt;
      if (xfer)   shadow <= '{hex: IN_HEX, dp: IN_DP, blank: IN_BLANK, colon: IN_COLON};
      if (commit) active <= shadow;
      case (state)
        BLANK: begin
          if (cnt == BLANK_END) begin
            state <= SCAN;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        end
        SCAN: begin
          if (cnt == SCAN_END) begin
            state <= BLANK;
            cnt   <= '0;
            digit <= digit + 2'd1;
          end else cnt <= cnt + CW'(1);
        end
        default: state <= BLANK;
      endcase
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with short scan/blank timing (slot 6, frame 24 cycles).
module tb_seg7_scan_driver;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0, in_valid_n = 1'b0;
  logic [15:0] in_hex = '0, in_hex_n = '0;
  logic [3:0]  in_dp = '0, in_dp_n = '0, in_blank = '0, in_blank_n = '0;
  logic        in_colon = 1'b0, in_colon_n = 1'b0;
  logic        in_ready, in_ready_n, frame_tick, frame_tick_n;
  logic [13:0] pins, pins_n;

  int n_run = 0, n_fail = 0, off = 0;

  always #5 CLK = ~CLK;

  seg7_scan_driver #(.C_SCAN_CYCLES(4), .C_BLANK_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_HEX(in_hex), .IN_DP(in_dp), .IN_BLANK(in_blank), .IN_COLON(in_colon),
    .FRAME_TICK(frame_tick), .PINS(pins)
  );

  seg7_scan_driver #(.C_SCAN_CYCLES(4), .C_BLANK_CYCLES(2),
                     .C_SEG_ACTIVE_LOW(1), .C_COM_ACTIVE_LOW(1)) dut_n (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid_n), .IN_READY(in_ready_n),
    .IN_HEX(in_hex_n), .IN_DP(in_dp_n), .IN_BLANK(in_blank_n), .IN_COLON(in_colon_n),
    .FRAME_TICK(frame_tick_n), .PINS(pins_n)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
    off += n;
  endtask

  task automatic step_to(input int k);
    if (k > off) step(k - off);
  endtask

  task automatic send(input bit sel, input logic [15:0] h, input logic [3:0] dp,
                      input logic [3:0] bl, input logic col);
    logic r;
    r = 1'b0;
    if (sel) begin
      in_hex_n = h; in_dp_n = dp; in_blank_n = bl; in_colon_n = col; in_valid_n = 1'b1;
    end else begin
      in_hex = h; in_dp = dp; in_blank = bl; in_colon = col; in_valid = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      r = sel ? in_ready_n : in_ready;
      step(1);
      if (r) break;
    end
    in_valid = 1'b0; in_valid_n = 1'b0;
    chk("send_accepted", {15'd0, r}, 16'd1);
  endtask

  task automatic wait_tick(input bit sel, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (sel ? frame_tick_n : frame_tick) begin found = 1'b1; break; end
    end
    chk(tag, {15'd0, found}, 16'd1);
    off = 0;
  endtask

  initial begin
    logic [7:0]  segtab [4];
    logic [15:0] exp;
    logic [3:0]  com;
    logic        bad;
    int s, d;
    segtab = '{8'h71, 8'h77, 8'hDB, 8'h06};

    // Reset state
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_pins", {2'b00, pins}, 16'h0000);
      chk("rst_ready", {15'd0, in_ready}, 16'd1);
      chk("rst_tick", {15'd0, frame_tick}, 16'd0);
    end
    RST = 1'b0;
    step(1); chk("post_rst_dark0", {2'b00, pins}, 16'h0000);
    chk("post_rst_notick", {15'd0, frame_tick}, 16'd0);
    step(1); chk("post_rst_dark1", {2'b00, pins}, 16'h0000);
    step(1); chk("first_scan_com0", {2'b00, pins}, 16'h0100);
    chk("post_rst_ready", {15'd0, in_ready}, 16'd1);

    // Full frame of 12AF with dp on digit2 and colon
    send(1'b0, 16'h12AF, 4'b0100, 4'b0000, 1'b1);
    wait_tick(1'b0, "t2_tick");
    for (int k = 0; k <= 24; k++) begin
      step_to(k);
      s = k % 6; d = (k / 6) % 4;
      exp = (s < 2) ? 16'h0000 : (16'h1000 | (16'h0100 << d) | {8'h00, segtab[d]});
      chk($sformatf("t2_pins_k%0d", k), {2'b00, pins}, exp);
      chk($sformatf("t2_tick_k%0d", k), {15'd0, frame_tick}, (k == 0) ? 16'd1 : 16'd0);
    end

    // Second request held while not ready is not captured early
    send(1'b0, 16'h3456, 4'b0000, 4'b0000, 1'b0);
    chk("t3_rdy_fall", {15'd0, in_ready}, 16'd0);
    in_hex = 16'h0008; in_dp = 4'b0001; in_blank = 4'b0000; in_colon = 1'b1; in_valid = 1'b1;
    wait_tick(1'b0, "t3_tick");
    chk("t3_rdy_back", {15'd0, in_ready}, 16'd1);
    chk("t3_tick_dark", {2'b00, pins}, 16'h0000);
    step(1); in_valid = 1'b0;
    chk("t3_y_taken", {15'd0, in_ready}, 16'd0);
    step_to(2);  chk("t3_x_shown", {2'b00, pins}, 16'h017D);
    step_to(23); chk("t3_no_early_tick", {15'd0, frame_tick}, 16'd0);
    step_to(24); chk("t3_y_tick", {15'd0, frame_tick}, 16'd1);
    step_to(26); chk("t3_y_shown", {2'b00, pins}, 16'h11FF);

    // Transfer on the frame-boundary cycle waits a full frame
    step_to(47);
    in_hex = 16'h000C; in_dp = 4'b0000; in_blank = 4'b1110; in_colon = 1'b0; in_valid = 1'b1;
    step(1); in_valid = 1'b0;
    chk("t4_no_tick", {15'd0, frame_tick}, 16'd0);
    chk("t4_taken", {15'd0, in_ready}, 16'd0);
    step_to(50); chk("t4_still_y", {2'b00, pins}, 16'h11FF);
    step_to(71); chk("t4_tick_not_early", {15'd0, frame_tick}, 16'd0);
    step_to(72); chk("t4_tick_24", {15'd0, frame_tick}, 16'd1);
    step_to(74); chk("t4_z_shown", {2'b00, pins}, 16'h0139);

    // Async reset mid-SCAN of digit2 with an update pending
    send(1'b0, 16'hFFFF, 4'hF, 4'h0, 1'b1);
    step_to(87); chk("t6_mid_scan_d2", {2'b00, pins}, 16'h0400);
    #2 RST = 1'b1;
    #1;
    chk("t6_async_pins", {2'b00, pins}, 16'h0000);
    chk("t6_async_ready", {15'd0, in_ready}, 16'd1);
    chk("t6_async_tick", {15'd0, frame_tick}, 16'd0);
    step(2); RST = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (frame_tick || pins[12] || (pins[7:0] != 8'h00)) bad = 1'b1;
    end
    chk("t6_pending_dropped", {15'd0, bad}, 16'd0);
    chk("t6_ready_after", {15'd0, in_ready}, 16'd1);

    // Active-low polarity with every digit blanked
    send(1'b1, 16'h8888, 4'hF, 4'hF, 1'b0);
    wait_tick(1'b1, "t5_tick");
    for (int k = 0; k < 24; k++) begin
      step_to(k);
      s = k % 6; d = (k / 6) % 4;
      com = (s < 2) ? 4'hF : ~(4'b0001 << d);
      chk($sformatf("t5_pins_k%0d", k), {3'b000, pins_n[12:0]}, {3'b000, 1'b1, com, 8'hFF});
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
